fetch_decode_buffer: RTL

Two-entry instruction buffer between the fetch stage and InstructionDecode in the LEGv8 64-bit datapath. It takes {instruction, PC} pairs from fetch under a valid/ready handshake and presents them in order to decode. It drops wrong-path words on a taken branch (PCSrc flush), substitutes NOP when empty, and stops the front end once the HALT opcode reaches decode.

---
 rtl/cpu_pkg.sv | 26 ++
 rtl/fetch_decode_buffer_if.sv | 30 +++
 rtl/ifid_slot.sv | 27 ++
 rtl/fetch_decode_buffer.sv | 133 +++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared LEGv8 front-end definitions used by fetch, the fetch/decode buffer
// and decode.
//   PC_W      : program counter width in bits
//   SLOT_W    : width of one buffered {pc, instruction} entry
//   NOP_WORD  : encoding presented to decode when nothing valid is buffered
//   HALT_OPC  : instr[31:21] value that marks the HALT instruction
//   occ_t     : buffer occupancy, which doubles as the buffer state
//   is_halt() : true when a 32-bit word carries the HALT opcode
package cpu_pkg;

  localparam int          PC_W     = 64;
  localparam int          SLOT_W   = PC_W + 32;
  localparam logic [31:0] NOP_WORD = 32'hD503201F;
  localparam logic [10:0] HALT_OPC = 11'h7FF;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_t;

  function automatic logic is_halt(input logic [31:0] instr);
    return instr[31:21] == HALT_OPC;
  endfunction

endpackage

// File: rtl/fetch_decode_buffer_if.sv
// Fetch-side and decode-side handshake bundle for the fetch/decode buffer.
//   f_valid/f_instr/f_pc : word offered by fetch
//   f_ready              : buffer can take the offered word this cycle
//   d_valid/d_instr/d_pc : head entry presented to decode
//   d_ready              : decode consumes the head this cycle
// modport slave  : the buffer itself
// modport master : the surrounding fetch/decode logic (or a testbench)
interface fetch_decode_buffer_if;
  import cpu_pkg::*;

  logic            f_valid;
  logic [31:0]     f_instr;
  logic [PC_W-1:0] f_pc;
  logic            f_ready;
  logic            d_valid;
  logic [31:0]     d_instr;
  logic [PC_W-1:0] d_pc;
  logic            d_ready;

  modport slave (
    input  f_valid, f_instr, f_pc, d_ready,
    output f_ready, d_valid, d_instr, d_pc
  );

  modport master (
    output f_valid, f_instr, f_pc, d_ready,
    input  f_ready, d_valid, d_instr, d_pc
  );

endinterface

// File: rtl/ifid_slot.sv
// One buffer entry: a {pc, instruction} register with load enable and clear.
//   clk   : rising-edge clock
//   reset : synchronous active-high reset, clears the entry
//   clear : synchronous clear (used when wrong-path words are discarded)
//   load  : capture d on this edge
//   d / q : entry input / registered entry
module ifid_slot
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              load,
  input  logic [SLOT_W-1:0] d,
  output logic [SLOT_W-1:0] q
);

  // Clear wins over load so a discarded word never lands in the entry.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/fetch_decode_buffer.sv
// Two-entry in-order instruction buffer between fetch and decode.
//   clk, reset    : rising-edge clock, synchronous active-high reset
//   bus (slave)   : fetch handshake in, decode handshake out
//   flush         : taken branch, discard every buffered word
//   halted        : sticky, HALT has been handed to decode
//   delivered_cnt : number of words handed to decode (wraps at 2^32)
// slot0 is the head presented to decode, slot1 the tail. The occupancy
// register is the state machine. Outputs come from registers only, so an
// accepted word reaches decode one cycle later.
module fetch_decode_buffer
  import cpu_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  fetch_decode_buffer_if.slave  bus,
  input  logic                  flush,
  output logic                  halted,
  output logic [31:0]           delivered_cnt
);

  occ_t              occ, occ_nxt;
  logic              halt_pending;
  logic              accept, deliver;
  logic              load0, load1;
  logic [SLOT_W-1:0] new_word, slot0_d, slot0_q, slot1_q;
  logic [31:0]       head_instr;
  logic [PC_W-1:0]   head_pc;

  assign new_word   = {bus.f_pc, bus.f_instr};
  assign head_instr = slot0_q[31:0];
  assign head_pc    = slot0_q[SLOT_W-1:32];

  // Once HALT is buffered, fetch is held off; once delivered, decode sees
  // nothing more until reset.
  assign bus.f_ready = (occ != FULL) && !halt_pending && !halted;
  assign bus.d_valid = (occ != EMPTY) && !halted;
  assign bus.d_instr = bus.d_valid ? head_instr : NOP_WORD;
  assign bus.d_pc    = bus.d_valid ? head_pc : '0;

  assign accept  = bus.f_valid && bus.f_ready;
  assign deliver = bus.d_valid && bus.d_ready;

  ifid_slot u_slot0 (
    .clk   (clk),
    .reset (reset),
    .clear (flush),
    .load  (load0),
    .d     (slot0_d),
    .q     (slot0_q)
  );

  ifid_slot u_slot1 (
    .clk   (clk),
    .reset (reset),
    .clear (flush),
    .load  (load1),
    .d     (new_word),
    .q     (slot1_q)
  );

  // Occupancy register.
  always_ff @(posedge clk) begin
    if (reset) begin
      occ <= EMPTY;
    end else begin
      occ <= occ_nxt;
    end
  end

  // Next occupancy and slot loads. In ONE with accept and deliver together
  // the head is consumed and replaced in place; in FULL a deliver shifts
  // the tail forward into the head.
  always_comb begin
    occ_nxt = occ;
    load0   = 1'b0;
    load1   = 1'b0;
    slot0_d = new_word;
    if (flush) begin
      occ_nxt = EMPTY;
    end else begin
      case (occ)
        EMPTY: begin
          if (accept) begin
            occ_nxt = ONE;
            load0   = 1'b1;
          end
        end
        ONE: begin
          if (accept && deliver) begin
            load0 = 1'b1;
          end else if (accept) begin
            occ_nxt = FULL;
            load1   = 1'b1;
          end else if (deliver) begin
            occ_nxt = EMPTY;
          end
        end
        FULL: begin
          if (deliver) begin
            occ_nxt = ONE;
            load0   = 1'b1;
            slot0_d = slot1_q;
          end
        end
        default: occ_nxt = EMPTY;
      endcase
    end
  end

  // HALT tracking and delivery counter. A deliver in a flush cycle still
  // really happened, so it counts and can still set halted; a HALT that is
  // only buffered is wrong-path and is forgotten on flush.
  always_ff @(posedge clk) begin
    if (reset) begin
      halt_pending  <= 1'b0;
      halted        <= 1'b0;
      delivered_cnt <= '0;
    end else begin
      if (deliver) begin
        delivered_cnt <= delivered_cnt + 32'd1;
      end
      if (deliver && is_halt(head_instr)) begin
        halted <= 1'b1;
      end
      if (flush) begin
        halt_pending <= 1'b0;
      end else if (accept && is_halt(bus.f_instr)) begin
        halt_pending <= 1'b1;
      end
    end
  end

endmodule
